// File: rtl/ls_multiple_seq.sv
// Load/store-multiple sequencer (lmw/stmw): issues one word beat per register
// rt..31 at consecutive word addresses through a req/ack handshake.
module ls_multiple_seq #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned GPR_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [GPR_IDX_W-1:0] rt,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 abort,
  input  logic                 ls_ack,
  output logic                 busy,
  output logic                 ls_req,
  output logic                 ls_we,
  output logic [ADDR_W-1:0]    ls_addr,
  output logic                 ls_first_cycle,
  output logic                 ls_multiple_inc,
  output logic [GPR_IDX_W-1:0] gpr_idx,
  output logic                 gpr_we,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [GPR_IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   store_q, store_d;
  logic                   first_q, first_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    addr_d          = addr_q;
    store_d         = store_q;
    first_d         = first_q;
    busy            = 1'b0;
    ls_req          = 1'b0;
    ls_we           = 1'b0;
    ls_addr         = '0;
    ls_first_cycle  = 1'b0;
    ls_multiple_inc = 1'b0;
    gpr_idx         = '0;
    gpr_we          = 1'b0;
    done            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ls_addr = addr_q;
        gpr_idx = idx_q;
        if (start && !abort) begin
          idx_d   = rt;
          addr_d  = base_addr;
          store_d = is_store;
          first_d = 1'b1;
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        busy            = 1'b1;
        ls_req          = 1'b1;
        ls_we           = store_q;
        ls_addr         = addr_q;
        gpr_idx         = idx_q;
        ls_first_cycle  = first_q;
        ls_multiple_inc = ~first_q;
        // abort wins over the handshake: no register write, no completion
        if (abort) begin
          state_d = S_IDLE;
        end else if (ls_ack) begin
          gpr_we = ~store_q;
          if (idx_q == '1) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + GPR_IDX_W'(1);
            addr_d  = addr_q + ADDR_W'(4);
            first_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = ~abort;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
